key_accumulator_ctrl: RTL and testbench
=======================================

// Module: key_accumulator_ctrl
// PURPOSE
//  Fabric-side controller for the pushbutton accumulator datapath: debounces the
//  active-low accumulate and clear keys, emits one pulse per clean press, adds the
//  switch value into an 8-bit LED accumulator on each accumulate press, zeroes it
//  on each clear press. Sits beside the SoC in the top level, driving LEDG directly.
// PARAMETERS
//  DATA_W           8        accumulator / switch / LED width
//  DEBOUNCE_CYCLES  500000   consecutive stable samples required (10 ms @ 50 MHz)
//  CNT_W            20       debounce counter width; must hold DEBOUNCE_CYCLES
// PORTS
//  clk_clk           in   1       system clock, 50 MHz
//  reset_reset_n     in   1       asynchronous active-low reset
//  key_accumulate_n  in   1       raw pushbutton, low = pressed, asynchronous
//  key_clear_n       in   1       raw pushbutton, low = pressed, asynchronous
//  sw                in   DATA_W  switch value added on accumulate, asynchronous
//  led               out  DATA_W  accumulator value
//  overflow          out  1       sticky: set when an add carried out of DATA_W
//  accumulate_pulse  out  1       1-cycle strobe per debounced accumulate press
//  clear_pulse       out  1       1-cycle strobe per debounced clear press
// BEHAVIOUR
//  Reset (async assert, sync release): led=0, overflow=0, both pulses=0, both
//   FSMs RELEASED, counters=0, key synchronizers=1 (released), sw sync=0.
//  Sync: each key through a 2-flop synchronizer; sw through a 2-flop bus sync
//   (quasi-static input; no per-bit coherency guarantee needed).
//  Per-key debounce FSM (identical, independent instances), counter cnt:
//   RELEASED:   synced key=0 -> PRESS_WAIT, cnt=1; else stay, cnt=0.
//   PRESS_WAIT: key=1 -> RELEASED, cnt=0 (bounce rejected);
//               key=0 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, pulse=1 next cycle;
//               else cnt++.
//   PRESSED:    pulse high only on the first PRESSED cycle; key=1 -> RELEASE_WAIT,
//               cnt=1; key held low -> stay, no further pulses.
//   RELEASE_WAIT: key=0 -> PRESSED, cnt=0, NO new pulse;
//               key=1 and cnt==DEBOUNCE_CYCLES-1 -> RELEASED; else cnt++.
//   DEBOUNCE_CYCLES<=1 is illegal (elaboration-time check).
//  Latency: key pin stable low from edge N -> pulse high in cycle
//   N+2+DEBOUNCE_CYCLES (2 sync + debounce); led updates on the following edge.
//  Accumulator (registered, acts on pulse cycle):
//   clear_pulse=1 -> led<=0, overflow<=0 (clear wins over simultaneous accumulate).
//   accumulate_pulse=1 only -> {carry,led}<=led+sw_sync (DATA_W+1 bit add, wrap
//    modulo 2^DATA_W); overflow<=overflow|carry.
//   neither -> hold.
//  Reset mid-debounce or mid-press: all state returns to reset values immediately;
//   a key still held at reset release is debounced afresh and yields one pulse.
//  Pulses and led are glitch-free register outputs.
// TESTING (bench uses DEBOUNCE_CYCLES=4, CNT_W=3)
//  1. sw=8'h05, accumulate held low 20 cycles -> exactly one accumulate_pulse,
//     asserted 6 cycles after first low sample edge; led=8'h05, overflow=0.
//  2. Bounce: accumulate low 3 cycles, high 1, low 3, high -> no pulse, led unchanged.
//  3. led=8'hFE, sw=8'h03, one clean press -> led=8'h01, overflow=1; second press
//     sw=8'h01 -> led=8'h02, overflow stays 1.
//  4. Both keys pressed same cycle, led=8'h10, sw=8'h22 -> both pulses same cycle;
//     led=8'h00, overflow=0 afterwards.
//  5. Release bounce: after press, key high 2 cycles then low again -> no second
//     pulse; clean release then new press -> second pulse.
//  6. reset_reset_n low mid PRESS_WAIT with led=8'h33 -> led=0 asynchronously,
//     no pulse; key still held at release -> one pulse 6 cycles later.

Source files
------------

// File: rtl/key_accumulator_ctrl.sv
// key_accumulator_ctrl: debounced pushbutton accumulator driving the LED bank
module key_accumulator_ctrl_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_n,
   output logic o_pulse
);
   typedef enum logic [1:0] {S_RELEASED, S_PRESS_WAIT, S_PRESSED, S_RELEASE_WAIT} state_t;
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   state_t           r_state;
   logic [1:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pulse;
   logic             w_key;
   assign w_key   = r_sync[1];
   assign o_pulse = r_pulse;
   // Synchronize the raw key, then require a full run of stable samples before changing state
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync  <= 2'b11;
         r_state <= S_RELEASED;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_key_n};
         r_pulse <= 1'b0;
         case (r_state)
            S_RELEASED: begin
               r_state <= w_key ? S_RELEASED : S_PRESS_WAIT;
               r_cnt   <= w_key ? '0 : CNT_W'(1);
            end
            S_PRESS_WAIT: begin
               if (w_key) begin
                  r_state <= S_RELEASED;
                  r_cnt   <= '0;
               end else if (r_cnt == LP_LAST) begin
                  r_state <= S_PRESSED;
                  r_cnt   <= '0;
                  r_pulse <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_PRESSED: begin
               r_state <= w_key ? S_RELEASE_WAIT : S_PRESSED;
               r_cnt   <= w_key ? CNT_W'(1) : '0;
            end
            default: begin
               if (!w_key) begin
                  r_state <= S_PRESSED;
                  r_cnt   <= '0;
               end else if (r_cnt == LP_LAST) begin
                  r_state <= S_RELEASED;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end
endmodule

module key_accumulator_ctrl #(
   parameter int DATA_W          = 8,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              key_accumulate_n,
   input  logic              key_clear_n,
   input  logic [DATA_W-1:0] sw,
   output logic [DATA_W-1:0] led,
   output logic              overflow,
   output logic              accumulate_pulse,
   output logic              clear_pulse
);
   if (DEBOUNCE_CYCLES <= 1 || longint'(DEBOUNCE_CYCLES - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cfg
      $error("key_accumulator_ctrl: DEBOUNCE_CYCLES must be > 1 and DEBOUNCE_CYCLES-1 must fit in CNT_W bits");
   end
   logic [DATA_W-1:0] r_sw_meta;
   logic [DATA_W-1:0] r_sw_sync;
   logic [DATA_W-1:0] r_led;
   logic              r_overflow;
   logic [DATA_W:0]   w_sum;
   logic              w_acc_pulse;
   logic              w_clr_pulse;
   key_accumulator_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_acc_db (
      .i_clk   (clk_clk),
      .i_rst_n (reset_reset_n),
      .i_key_n (key_accumulate_n),
      .o_pulse (w_acc_pulse)
   );
   key_accumulator_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clr_db (
      .i_clk   (clk_clk),
      .i_rst_n (reset_reset_n),
      .i_key_n (key_clear_n),
      .o_pulse (w_clr_pulse)
   );
   assign w_sum            = {1'b0, r_led} + {1'b0, r_sw_sync};
   assign led              = r_led;
   assign overflow         = r_overflow;
   assign accumulate_pulse = w_acc_pulse;
   assign clear_pulse      = w_clr_pulse;
   // Bus-synchronize the quasi-static switches
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_sw_meta <= '0;
         r_sw_sync <= '0;
      end else begin
         r_sw_meta <= sw;
         r_sw_sync <= r_sw_meta;
      end
   end
   // Accumulate on press, clear wins when both keys fire together; overflow is sticky until clear
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_led      <= '0;
         r_overflow <= 1'b0;
      end else if (w_clr_pulse) begin
         r_led      <= '0;
         r_overflow <= 1'b0;
      end else if (w_acc_pulse) begin
         r_led      <= w_sum[DATA_W-1:0];
         r_overflow <= r_overflow | w_sum[DATA_W];
      end
   end
endmodule

// File: tb/tb_key_accumulator_ctrl.sv
// tb_key_accumulator_ctrl: directed vectors and corner sequences for the key accumulator
module tb_key_accumulator_ctrl;
   logic       clk_clk = 1'b0;
   logic       reset_reset_n = 1'b0;
   logic       key_accumulate_n = 1'b1;
   logic       key_clear_n = 1'b1;
   logic [7:0] sw = 8'h00;
   logic [7:0] led;
   logic       overflow, accumulate_pulse, clear_pulse;
   int checks = 0, errors = 0;
   int cyc = 0, n_acc = 0, n_clr = 0, acc_cyc = -1, clr_cyc = -1;

   key_accumulator_ctrl #(.DATA_W(8), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .key_accumulate_n(key_accumulate_n),
      .key_clear_n(key_clear_n), .sw(sw), .led(led), .overflow(overflow),
      .accumulate_pulse(accumulate_pulse), .clear_pulse(clear_pulse));

   always #5 clk_clk = ~clk_clk;
   always @(posedge clk_clk) cyc <= cyc + 1;
   always @(negedge clk_clk) begin
      if (accumulate_pulse) begin n_acc++; acc_cyc = cyc; end
      if (clear_pulse) begin n_clr++; clr_cyc = cyc; end
   end

   typedef struct {
      logic [7:0] sw;
      bit         acc;
      bit         clr;
      logic [7:0] exp_led;
      logic       exp_ovf;
   } vec_t;
   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_clk);
      #1;
   endtask

   initial begin
      int a0, c0, t0;
      vecs[0] = '{8'h05, 1, 0, 8'h05, 1'b0};
      vecs[1] = '{8'hF9, 1, 0, 8'hFE, 1'b0};
      vecs[2] = '{8'h03, 1, 0, 8'h01, 1'b1};
      vecs[3] = '{8'h01, 1, 0, 8'h02, 1'b1};
      vecs[4] = '{8'h00, 0, 1, 8'h00, 1'b0};
      vecs[5] = '{8'h10, 1, 0, 8'h10, 1'b0};
      vecs[6] = '{8'h22, 1, 1, 8'h00, 1'b0};
      vecs[7] = '{8'hFF, 1, 0, 8'hFF, 1'b0};
      vecs[8] = '{8'h01, 1, 0, 8'h00, 1'b1};
      vecs[9] = '{8'h80, 0, 1, 8'h00, 1'b0};
      #12;
      chk("reset_led", 32'(led), 32'h0);
      chk("reset_ovf", 32'(overflow), 32'h0);
      chk("reset_acc_pulse", 32'(accumulate_pulse), 32'h0);
      chk("reset_clr_pulse", 32'(clear_pulse), 32'h0);
      step(2);
      reset_reset_n = 1'b1;
      step(3);
      for (int i = 0; i < 10; i++) begin
         sw = vecs[i].sw;
         step(3);
         a0 = n_acc; c0 = n_clr; t0 = cyc;
         key_accumulate_n = ~vecs[i].acc;
         key_clear_n = ~vecs[i].clr;
         step(20);
         key_accumulate_n = 1'b1;
         key_clear_n = 1'b1;
         step(10);
         chk($sformatf("v%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
         chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
         chk($sformatf("v%0d_acc_cnt", i), 32'(n_acc - a0), 32'(vecs[i].acc));
         chk($sformatf("v%0d_clr_cnt", i), 32'(n_clr - c0), 32'(vecs[i].clr));
         if (vecs[i].acc) chk($sformatf("v%0d_acc_lat", i), 32'(acc_cyc - t0), 32'd6);
         if (vecs[i].acc && vecs[i].clr) chk($sformatf("v%0d_same_cycle", i), 32'(acc_cyc), 32'(clr_cyc));
      end
      // press bounce: 3 low, 1 high, 3 low never reaches 4 stable samples
      sw = 8'h07;
      a0 = n_acc;
      key_accumulate_n = 1'b0; step(3);
      key_accumulate_n = 1'b1; step(1);
      key_accumulate_n = 1'b0; step(3);
      key_accumulate_n = 1'b1; step(12);
      chk("bounce_no_pulse", 32'(n_acc - a0), 32'd0);
      chk("bounce_led", 32'(led), 32'h00);
      // release bounce: short high glitch while pressed gives no second pulse
      a0 = n_acc;
      key_accumulate_n = 1'b0; step(8);
      key_accumulate_n = 1'b1; step(2);
      key_accumulate_n = 1'b0; step(8);
      chk("relbounce_one_pulse", 32'(n_acc - a0), 32'd1);
      chk("relbounce_led", 32'(led), 32'h07);
      key_accumulate_n = 1'b1; step(10);
      key_accumulate_n = 1'b0; step(8);
      key_accumulate_n = 1'b1; step(10);
      chk("relbounce_second_pulse", 32'(n_acc - a0), 32'd2);
      chk("relbounce_led2", 32'(led), 32'h0E);
      // reset mid PRESS_WAIT with led=33, key held through release
      key_clear_n = 1'b0; step(8); key_clear_n = 1'b1; step(10);
      sw = 8'h33; step(3);
      key_accumulate_n = 1'b0; step(8); key_accumulate_n = 1'b1; step(10);
      chk("pre_reset_led", 32'(led), 32'h33);
      a0 = n_acc;
      key_accumulate_n = 1'b0; step(4);
      reset_reset_n = 1'b0;
      #1;
      chk("async_reset_led", 32'(led), 32'h0);
      step(3);
      chk("reset_no_pulse", 32'(n_acc - a0), 32'd0);
      reset_reset_n = 1'b1;
      t0 = cyc;
      step(12);
      chk("post_reset_one_pulse", 32'(n_acc - a0), 32'd1);
      chk("post_reset_lat", 32'(acc_cyc - t0), 32'd6);
      chk("post_reset_led", 32'(led), 32'h33);
      key_accumulate_n = 1'b1; step(10);
      chk("post_reset_no_extra", 32'(n_acc - a0), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
